multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port instr, input, 32: instruction word from the instruction register; valid from DECODE onward.
REQ-005 SHALL have ports imem_req (output, 1: fetch request) and imem_ack (input, 1: fetch data valid).
REQ-006 SHALL have ports dmem_req (output, 1: data access request), dmem_we (output, 1: 1 = store) and dmem_ack (input, 1: access done).
REQ-007 SHALL have port alu_zero, input, 1: ALU zero flag.
REQ-008 SHALL have ports select_aluPerformance (output, 2: 00 addu, 01 or, 10 subu, 11 unused) and select_anotherAluSource (output, 1: 1 = zero-extended imm16, 0 = register).
REQ-009 SHALL have outputs ir_we (1), pc_we (1), pc_src (2: 00 pc+4, 01 branch target, 10 jump target), reg_we (1), reg_dst (1: 1 = rd, 0 = rt) and mem_to_reg (1).
REQ-010 SHALL have outputs illegal (1: sticky illegal-opcode flag), state (3: debug encoding) and retired (CNT_W: retired-instruction count).

Function
REQ-011 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-012 SHALL support: addu (op 000000, funct 100001), subu (op 000000, funct 100011), ori (001101), lw (100011), sw (101011), beq (000100), j (000010); any other encoding is illegal.
REQ-013 In FETCH: imem_req=1 until imem_ack; in the ack cycle ir_we=1, pc_we=1, pc_src=00; next state DECODE.
REQ-014 DECODE SHALL last one cycle and register the op class: j -> pc_we=1, pc_src=10, retire, go to FETCH; illegal -> HALT; all others -> EXEC.
REQ-015 EXEC select values: addu 00/0 -> WB; subu 10/0 -> WB; ori 01/1 -> WB; lw/sw 00/1 -> MEM; beq 10/0, with pc_we=1 and pc_src=01 in the same cycle iff alu_zero=1, then retire and go to FETCH.
REQ-016 In MEM: dmem_req=1 and dmem_we=(op==sw) held until dmem_ack; on ack, lw -> WB; sw -> retire and go to FETCH.
REQ-017 WB SHALL last one cycle: reg_we=1; reg_dst=1 only for addu/subu; mem_to_reg=1 only for lw; then retire and go to FETCH.
REQ-018 select_aluPerformance/select_anotherAluSource SHALL be stable from EXEC through WB of the same instruction, and 00/0 in FETCH, DECODE and HALT.
REQ-019 All strobes (ir_we, pc_we, reg_we, imem_req, dmem_req, dmem_we) SHALL be 0 outside the states listed above.
REQ-020 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-021 retired SHALL increment by 1 in each retire cycle and wrap from 2^CNT_W-1 to 0.
REQ-022 Latency with same-cycle acks: j 2, beq 3, sw 4, addu/subu/ori 4, lw 5 cycles.
REQ-023 HALT: illegal=1, all strobes 0, no exit except reset.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force FETCH, illegal=0, retired=0 and all outputs 0, including mid-FETCH/MEM; a pending ack in that cycle SHALL be ignored.
REQ-025 In the first cycle after reset release, imem_req SHALL be 1.

Structure
REQ-026 Opcode/funct constants, ALU select codes, pc_src codes and state encodings SHALL reside in shared package mips_pkg.
REQ-027 Instruction decoding (instr -> op class, illegal) SHALL be a combinational sub-module ctrl_decoder; the FSM, counter and output logic SHALL be in multicycle_ctrl.

Verification
REQ-028 addu ($3=$1+$2, instr 0x00221821), acks same cycle -> states FETCH/DECODE/EXEC/WB; EXEC selects 00/0; reg_we=1 and reg_dst=1 in WB; retired 0->1 after 4 cycles.
REQ-029 ori with imm16=0x0093 -> EXEC selects 01/1; WB reg_dst=0, mem_to_reg=0.
REQ-030 beq with alu_zero=1, then with alu_zero=0 -> pc_we=1, pc_src=01 in EXEC only in the first case; 3 cycles each.
REQ-031 lw with dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=0 for 4 cycles; WB mem_to_reg=1; total 8 cycles.
REQ-032 Opcode 111111 -> HALT, illegal=1, no requests for 10 cycles; rst_n=0 for one edge -> FETCH, illegal=0, retired=0.
REQ-033 rst_n=0 mid-MEM of sw with dmem_ack=1 in the same cycle -> no retire; next state FETCH; retired=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, ALU and
// PC-source selects, FSM state and decoded operation class.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [1:0] ALU_ADDU = 2'b00;
    localparam logic [1:0] ALU_OR   = 2'b01;
    localparam logic [1:0] ALU_SUBU = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_ILLEGAL
    } op_class_t;

    // Returns {alu operation, second-source select} used from EXEC to WB.
    function automatic logic [2:0] alu_ctl(input op_class_t c);
        case (c)
            C_SUBU, C_BEQ: alu_ctl = {ALU_SUBU, 1'b0};
            C_ORI:         alu_ctl = {ALU_OR, 1'b1};
            C_LW, C_SW:    alu_ctl = {ALU_ADDU, 1'b1};
            default:       alu_ctl = {ALU_ADDU, 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction classifier: maps opcode/funct to an operation
// class and flags every unsupported encoding as illegal.
module ctrl_decoder
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output op_class_t   op_class,
    output logic        illegal
);

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[25:6];

    always_comb begin
        op_class = C_ILLEGAL;
        case (instr[31:26])
            OP_RTYPE: begin
                if (instr[5:0] == FN_ADDU)
                    op_class = C_ADDU;
                else if (instr[5:0] == FN_SUBU)
                    op_class = C_SUBU;
            end
            OP_ORI:  op_class = C_ORI;
            OP_LW:   op_class = C_LW;
            OP_SW:   op_class = C_SW;
            OP_BEQ:  op_class = C_BEQ;
            OP_J:    op_class = C_J;
            default: op_class = C_ILLEGAL;
        endcase
    end

    assign illegal = (op_class == C_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes and counts retired instructions.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             alu_zero,
    output logic [1:0]       select_aluPerformance,
    output logic             select_anotherAluSource,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t           st;
    op_class_t        cls;
    op_class_t        dec_class;
    logic             dec_illegal;
    logic [1:0]       alu_sel_q;
    logic             alu_src_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    ctrl_decoder u_decoder (
        .instr    (instr),
        .op_class (dec_class),
        .illegal  (dec_illegal)
    );

    assign retire = (st == S_DECODE && dec_class == C_J) ||
                    (st == S_EXEC && cls == C_BEQ) ||
                    (st == S_MEM && cls == C_SW && dmem_ack) ||
                    (st == S_WB);

    // ALU selects are loaded on entry to EXEC and cleared on every return to FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= S_FETCH;
            cls       <= C_ADDU;
            alu_sel_q <= 2'b00;
            alu_src_q <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            case (st)
                S_FETCH: begin
                    if (imem_ack)
                        st <= S_DECODE;
                end
                S_DECODE: begin
                    cls <= dec_class;
                    if (dec_class == C_J) begin
                        st <= S_FETCH;
                    end else if (dec_illegal) begin
                        st        <= S_HALT;
                        illegal_q <= 1'b1;
                    end else begin
                        st                     <= S_EXEC;
                        {alu_sel_q, alu_src_q} <= alu_ctl(dec_class);
                    end
                end
                S_EXEC: begin
                    if (cls == C_LW || cls == C_SW) begin
                        st <= S_MEM;
                    end else if (cls == C_BEQ) begin
                        st                     <= S_FETCH;
                        {alu_sel_q, alu_src_q} <= 3'b000;
                    end else begin
                        st <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (cls == C_LW) begin
                            st <= S_WB;
                        end else begin
                            st                     <= S_FETCH;
                            {alu_sel_q, alu_src_q} <= 3'b000;
                        end
                    end
                end
                S_WB: begin
                    st                     <= S_FETCH;
                    {alu_sel_q, alu_src_q} <= 3'b000;
                end
                S_HALT: st <= S_HALT;
                default: st <= S_FETCH;
            endcase
            if (retire)
                retired_q <= retired_q + 1'b1;
        end
    end

    // Strobes are masked while reset is asserted so a pending ack has no effect.
    always_comb begin
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        if (rst_n) begin
            case (st)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_class == C_J) begin
                        pc_we  = 1'b1;
                        pc_src = PC_JUMP;
                    end
                end
                S_EXEC: begin
                    if (cls == C_BEQ && alu_zero) begin
                        pc_we  = 1'b1;
                        pc_src = PC_BRANCH;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls == C_SW);
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = (cls == C_ADDU || cls == C_SUBU);
                    mem_to_reg = (cls == C_LW);
                end
                default: ;
            endcase
        end
    end

    assign select_aluPerformance   = alu_sel_q;
    assign select_anotherAluSource = alu_src_q;
    assign illegal                 = illegal_q;
    assign state                   = st;
    assign retired                 = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expectations are
// queued when an instruction is issued and popped as the FSM completes it.
module tb_multicycle_ctrl;
    import mips_pkg::*;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic [31:0]   instr;
    logic          imem_req, imem_ack;
    logic          dmem_req, dmem_we, dmem_ack;
    logic          alu_zero;
    logic [1:0]    select_aluPerformance;
    logic          select_anotherAluSource;
    logic          ir_we, pc_we, reg_we, reg_dst, mem_to_reg;
    logic [1:0]    pc_src;
    logic          illegal;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .instr                   (instr),
        .imem_req                (imem_req),
        .imem_ack                (imem_ack),
        .dmem_req                (dmem_req),
        .dmem_we                 (dmem_we),
        .dmem_ack                (dmem_ack),
        .alu_zero                (alu_zero),
        .select_aluPerformance   (select_aluPerformance),
        .select_anotherAluSource (select_anotherAluSource),
        .ir_we                   (ir_we),
        .pc_we                   (pc_we),
        .pc_src                  (pc_src),
        .reg_we                  (reg_we),
        .reg_dst                 (reg_dst),
        .mem_to_reg              (mem_to_reg),
        .illegal                 (illegal),
        .state                   (state),
        .retired                 (retired)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ret_model = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] I_ADDU = 32'h0022_1821;
    localparam logic [31:0] I_SUBU = 32'h0022_1823;
    localparam logic [31:0] I_ORI  = 32'h3422_0093;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] got);
        logic [31:0] want;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check(tag, got, want);
    endtask

    // Reference model: 0 addu 1 subu 2 ori 3 lw 4 sw 5 beq 6 j 7 illegal
    function automatic int model_class(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'b000000 && fn == 6'b100001) return 0;
        if (op == 6'b000000 && fn == 6'b100011) return 1;
        if (op == 6'b001101) return 2;
        if (op == 6'b100011) return 3;
        if (op == 6'b101011) return 4;
        if (op == 6'b000100) return 5;
        if (op == 6'b000010) return 6;
        return 7;
    endfunction

    task automatic expect_instr(input logic [31:0] ins, input int idly, input int ddly,
                                input logic zero);
        int c, lat, dreq, dwe;
        logic [2:0] exsel, expc, wbsel, wbf;
        c = model_class(ins);
        exsel = 3'b111; expc = 3'b000; wbsel = 3'b111; wbf = 3'b000;
        dreq = 0; dwe = 0;
        case (c)
            0: begin lat = 4; exsel = 3'b000; wbsel = 3'b000; wbf = 3'b110; end
            1: begin lat = 4; exsel = 3'b100; wbsel = 3'b100; wbf = 3'b110; end
            2: begin lat = 4; exsel = 3'b011; wbsel = 3'b011; wbf = 3'b100; end
            3: begin lat = 5 + ddly; exsel = 3'b001; wbsel = 3'b001; wbf = 3'b101;
                     dreq = ddly + 1; end
            4: begin lat = 4 + ddly; exsel = 3'b001; dreq = ddly + 1; dwe = ddly + 1; end
            5: begin lat = 3; exsel = 3'b100; expc = zero ? 3'b101 : 3'b000; end
            6: lat = 2;
            default: lat = 2;
        endcase
        exp_q.push_back(32'(lat + idly));
        exp_q.push_back({29'd0, exsel});
        exp_q.push_back({29'd0, expc});
        exp_q.push_back({29'd0, wbsel});
        exp_q.push_back({29'd0, wbf});
        exp_q.push_back(32'(dreq));
        exp_q.push_back(32'(dwe));
        if (c != 7) ret_model = (ret_model + 1) % (1 << CW);
        exp_q.push_back(32'(ret_model));
    endtask

    // driver: one instruction from FETCH until the next FETCH (or HALT)
    task automatic run_instr(input logic [31:0] ins, input int idly, input int ddly,
                             input logic zero, output logic [31:0] trace);
        int cyc, fw, mw, dreq, dwe, irw, idle_bad;
        logic left;
        logic [2:0] exsel, expc, wbsel, wbf;
        expect_instr(ins, idly, ddly, zero);
        cyc = 0; fw = 0; mw = 0; dreq = 0; dwe = 0; irw = 0; idle_bad = 0; left = 1'b0;
        exsel = 3'b111; expc = 3'b000; wbsel = 3'b111; wbf = 3'b000; trace = '0;
        instr = ins;
        alu_zero = zero;
        while (cyc < 60) begin
            @(negedge clk);
            imem_ack = (state == S_FETCH) && (fw == idly);
            dmem_ack = (state == S_MEM) && (mw == ddly);
            #1;
            trace = {trace[28:0], state};
            case (state)
                S_EXEC: begin
                    exsel = {select_aluPerformance, select_anotherAluSource};
                    expc  = {pc_we, pc_src};
                end
                S_WB: begin
                    wbsel = {select_aluPerformance, select_anotherAluSource};
                    wbf   = {reg_we, reg_dst, mem_to_reg};
                end
                S_FETCH, S_DECODE: begin
                    if ({select_aluPerformance, select_anotherAluSource} != 3'b000)
                        idle_bad++;
                end
                default: ;
            endcase
            dreq += int'(dmem_req);
            dwe  += int'(dmem_we);
            irw  += int'(ir_we);
            if (state == S_FETCH) fw++;
            if (state == S_MEM) mw++;
            cyc++;
            @(posedge clk);
            #1;
            if (state != S_FETCH) left = 1'b1;
            if ((state == S_FETCH && left) || state == S_HALT) break;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        sb_check("latency", cyc);
        sb_check("exec_sel", {29'd0, exsel});
        sb_check("exec_pc", {29'd0, expc});
        sb_check("wb_sel", {29'd0, wbsel});
        sb_check("wb_flags", {29'd0, wbf});
        sb_check("dmem_req_cycles", dreq);
        sb_check("dmem_we_cycles", dwe);
        sb_check("retired", {28'd0, retired});
        check("ir_we_cycles", irw, 1);
        check("idle_sel", idle_bad, 0);
    endtask

    logic [31:0] tr;
    logic [31:0] table_i [7];
    int          quiet;

    initial begin
        table_i[0] = I_ADDU; table_i[1] = I_SUBU; table_i[2] = I_ORI; table_i[3] = I_LW;
        table_i[4] = I_SW;   table_i[5] = I_BEQ;  table_i[6] = I_J;
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instr = I_ADDU; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, S_FETCH);
        check("rst_illegal", illegal, 0);
        check("rst_retired", retired, 0);
        check("rst_imem_req", imem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("req_after_reset", imem_req, 1);

        run_instr(I_ADDU, 0, 0, 1'b0, tr);
        check("addu_trace", tr[11:0], 32'h054);
        run_instr(I_ORI, 0, 0, 1'b0, tr);
        run_instr(I_BEQ, 0, 0, 1'b1, tr);
        run_instr(I_BEQ, 0, 0, 1'b0, tr);
        run_instr(I_LW, 0, 3, 1'b0, tr);
        run_instr(I_SW, 1, 2, 1'b0, tr);
        run_instr(I_J, 0, 0, 1'b0, tr);
        run_instr(I_SUBU, 2, 0, 1'b0, tr);
        for (int i = 0; i < 16; i++)
            run_instr(table_i[$urandom_range(0, 6)], $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), tr);

        // illegal opcode: halt and stay quiet until reset
        run_instr(I_BAD, 0, 0, 1'b0, tr);
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            #1;
            quiet += int'(imem_req | dmem_req | dmem_we | ir_we | pc_we | reg_we);
        end
        check("halt_quiet", quiet, 0);
        check("halt_state", state, S_HALT);
        check("halt_illegal", illegal, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("halt_rst_state", state, S_FETCH);
        check("halt_rst_illegal", illegal, 0);
        check("halt_rst_retired", retired, 0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        ret_model = 0;

        // reset in the middle of a store with dmem_ack pending
        instr = I_SW;
        for (int k = 0; k < 20 && state != S_MEM; k++) begin
            @(negedge clk);
            imem_ack = (state == S_FETCH);
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        check("sw_in_mem", state, S_MEM);
        @(negedge clk);
        dmem_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        check("sw_rst_dmem_req", dmem_req, 0);
        @(posedge clk);
        #1;
        check("sw_rst_state", state, S_FETCH);
        check("sw_rst_retired", retired, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b0;
        run_instr(I_ADDU, 0, 0, 1'b0, tr);

        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
